// File: rtl/golay_dec_ctrl.sv
// Extended Golay (24,12) decode sequencer: syndrome, 26-candidate scan, correction.
// Optional error counters are enabled by defining GOLAY_ERR_CNT_EN.
module golay_dec_ctrl #(
  parameter int EARLY_EXIT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [23:0] DIN,
  output logic        BUSY,
  output logic        DONE,
  output logic [11:0] DOUT,
  output logic [1:0]  NERR,
`ifdef GOLAY_ERR_CNT_EN
  input  logic        CNT_CLR,
  output logic [15:0] CORR_CNT,
  output logic [15:0] UNC_CNT,
`endif
  output logic        UNCORR
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYN, S_CHK1, S_MULB, S_CHK2, S_FIN
  } state_t;

  localparam logic EE = (EARLY_EXIT != 0);

  function automatic logic [11:0] brow(input logic [3:0] i);
    logic [11:0] r;
    case (i)
      4'd0:    r = 12'hDC5;
      4'd1:    r = 12'hB8B;
      4'd2:    r = 12'h717;
      4'd3:    r = 12'hE2D;
      4'd4:    r = 12'hC5B;
      4'd5:    r = 12'h8B7;
      4'd6:    r = 12'h16F;
      4'd7:    r = 12'h2DD;
      4'd8:    r = 12'h5B9;
      4'd9:    r = 12'hB71;
      4'd10:   r = 12'h6E3;
      4'd11:   r = 12'hFFE;
      default: r = 12'h000;
    endcase
    return r;
  endfunction

  // Bit 11 is column 0, so v[11-k] selects row b_k.
  function automatic logic [11:0] mulb(input logic [11:0] v);
    logic [11:0] acc;
    acc = '0;
    for (int k = 0; k < 12; k++)
      if (v[11-k]) acc = acc ^ brow(4'(k));
    return acc;
  endfunction

  function automatic logic [3:0] popc(input logic [11:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 12; i++)
      n = n + {3'b0, v[i]};
    return n;
  endfunction

  state_t      state_q;
  logic [11:0] r1_q, r2_q, s_q, t_q;
  logic [11:0] e1_q, det_cand_q, dout_q;
  logic [3:0]  j_q, det_j_q;
  logic        det_vld_q, det_hit_q, det_ph_q;
  logic        hit_q, busy_q, done_q, unc_q;
  logic [1:0]  wt_q, nerr_q;

  logic        issue_c, chk_c, stop_c, ok_c;
  logic [11:0] cand_c, e1_c;
  logic [3:0]  wsum_c;
  logic [1:0]  wt_c;

  // Unit offsets (j>0) already carry one error, so the candidate may hold two.
  always_comb begin
    issue_c = (state_q == S_CHK1) ||
              ((state_q == S_CHK2) && (j_q <= 4'd12));
    cand_c  = (state_q == S_CHK2) ? t_q : s_q;
    if (j_q != 4'd0) cand_c = cand_c ^ brow(j_q - 4'd1);
    ok_c    = (j_q == 4'd0) ? (popc(cand_c) <= 4'd3)
                            : (popc(cand_c) <= 4'd2);
    chk_c   = det_vld_q && det_hit_q && !hit_q;
    stop_c  = EE && chk_c;
    e1_c    = '0;
    if (det_ph_q) e1_c = det_cand_q;
    else if (det_j_q != 4'd0) e1_c = 12'h800 >> (det_j_q - 4'd1);
    wsum_c  = popc(det_cand_q) + {3'b0, det_j_q != 4'd0};
    wt_c    = (wsum_c > 4'd3) ? 2'd3 : wsum_c[1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      r1_q       <= '0;
      r2_q       <= '0;
      s_q        <= '0;
      t_q        <= '0;
      e1_q       <= '0;
      det_cand_q <= '0;
      dout_q     <= '0;
      j_q        <= '0;
      det_j_q    <= '0;
      det_vld_q  <= 1'b0;
      det_hit_q  <= 1'b0;
      det_ph_q   <= 1'b0;
      hit_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      unc_q      <= 1'b0;
      wt_q       <= '0;
      nerr_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      det_vld_q <= 1'b0;
      if (issue_c) begin
        det_vld_q  <= 1'b1;
        det_hit_q  <= ok_c;
        det_cand_q <= cand_c;
        det_j_q    <= j_q;
        det_ph_q   <= (state_q == S_CHK2);
      end
      if (chk_c) begin
        hit_q <= 1'b1;
        e1_q  <= e1_c;
        wt_q  <= wt_c;
      end
      unique case (state_q)
        S_IDLE: begin
          if (START && !done_q) begin
            r1_q    <= DIN[23:12];
            r2_q    <= DIN[11:0];
            busy_q  <= 1'b1;
            hit_q   <= 1'b0;
            state_q <= S_SYN;
          end
        end
        S_SYN: begin
          s_q     <= mulb(r1_q) ^ r2_q;
          j_q     <= '0;
          state_q <= S_CHK1;
        end
        S_CHK1: begin
          j_q <= j_q + 4'd1;
          if (stop_c) state_q <= S_FIN;
          else if (j_q == 4'd12) state_q <= S_MULB;
        end
        S_MULB: begin
          t_q     <= mulb(s_q);
          j_q     <= '0;
          state_q <= stop_c ? S_FIN : S_CHK2;
        end
        S_CHK2: begin
          j_q <= j_q + 4'd1;
          if (stop_c || (j_q == 4'd14)) state_q <= S_FIN;
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          dout_q  <= hit_q ? (r1_q ^ e1_q) : r1_q;
          nerr_q  <= hit_q ? wt_q : 2'd0;
          unc_q   <= !hit_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign DOUT   = dout_q;
  assign NERR   = nerr_q;
  assign UNCORR = unc_q;

`ifdef GOLAY_ERR_CNT_EN
  logic [15:0] corr_cnt_q, unc_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST || CNT_CLR) begin
      corr_cnt_q <= '0;
      unc_cnt_q  <= '0;
    end else if (done_q) begin
      if ((nerr_q != 2'd0) && (corr_cnt_q != 16'hFFFF))
        corr_cnt_q <= corr_cnt_q + 16'd1;
      if (unc_q && (unc_cnt_q != 16'hFFFF))
        unc_cnt_q <= unc_cnt_q + 16'd1;
    end
  end

  assign CORR_CNT = corr_cnt_q;
  assign UNC_CNT  = unc_cnt_q;
`endif

endmodule

// File: doc/golay_dec_ctrl.md
Name: golay_dec_ctrl

Overview:
- Sequencer for extended Golay (24,12) decoding of PROM ECC words.
- Computes the syndrome and steps up to 26 candidate 12-bit vectors through a single registered weight<=3 detector (1-cycle latency).
- Selects the error pattern, corrects the 12-bit message, and reports error weight or uncorrectable status.
- Sits between the PROM read path and the configuration loader: one decode per START.

Parameters:
- EARLY_EXIT, 1, 1 = finish at the first candidate hit; 0 = always scan all candidates (constant latency 31, first hit kept).

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous active-high reset
- START  input  1  1-cycle request; sampled only in IDLE
- DIN  input  24  received word; DIN[23:12] = r1 (message), DIN[11:0] = r2 (parity); sampled with START
- BUSY  output  1  high from the cycle after START is accepted until DONE
- DONE  output  1  1-cycle pulse; DOUT, NERR and UNCORR are valid and held until the next DONE
- DOUT  output  12  corrected message r1^e1; raw r1 when uncorrectable
- NERR  output  2  weight of the applied error pattern (0..3)
- UNCORR  output  1  no candidate found

Behaviour:
- Clock and reset: one clock (CLK). Reset is synchronous and active-high (RST).
- Reset values: BUSY=0, DONE=0, DOUT=0, NERR=0, UNCORR=0, state=IDLE.
- RST mid-decode aborts immediately; no DONE is produced.
- Code: G=[I|B]. Bit 11 of each 12-bit vector is column 0.
- B rows b0..b11: DC5, B8B, 717, E2D, C5B, 8B7, 16F, 2DD, 5B9, B71, 6E3, FFE (hex).
- B is symmetric and B·B=I. u_i is the unit vector for column i.
- States: IDLE -> SYN -> CHK1 -> MULB -> CHK2 -> FIN -> IDLE.
- SYN: register s = r1·B xor r2.
- CHK1: issue one candidate per cycle, index j=0..12.
  - j=0 issues s.
  - j=i+1 issues s^b_i.
  - The weight check result returns 1 cycle after issue.
- MULB: register t = s·B.
- CHK2: issue candidates j=0..12.
  - j=0 issues t.
  - j=i+1 issues t^b_i.
- Error pattern (e1,e2) on a hit:
  - CHK1 j=0: (0, s).
  - CHK1 j=i+1: (u_i, s^b_i).
  - CHK2 j=0: (t, 0).
  - CHK2 j=i+1: (t^b_i, u_i).
- Outputs on a hit: NERR = popcount(e1)+popcount(e2). A hit never produces a count >3.
- Miss handling: a candidate issued after a hit (the pipeline shadow) is discarded. If both phases miss, UNCORR=1 and NERR=0.
- Latency, with START accepted at t0 and DONE at t0+L:
  - Phase-1 hit at j: L = 4+j.
  - Phase-2 hit at j: L = 18+j.
  - Uncorrectable: L = 31.
  - EARLY_EXIT=0: L = 31 always.
- START while BUSY is ignored. A START in the DONE cycle is ignored. Earliest new accept is DONE+1.
- DIN is captured at accept; later DIN changes have no effect.

Optional Feature:
- Macro GOLAY_ERR_CNT_EN.
- When defined, adds these ports:
  - CNT_CLR input 1
  - CORR_CNT output 16
  - UNC_CNT output 16
- CORR_CNT increments on DONE with NERR>0. UNC_CNT increments on DONE with UNCORR=1.
- Both counters saturate at FFFF. They clear on RST or CNT_CLR.
- CNT_CLR coinciding with an increment: clear wins.
- When undefined, the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- Valid codeword, message A5C -> DONE at t0+4; DOUT=A5C, NERR=0, UNCORR=0.
- Same codeword with 3 parity bits flipped (DIN ^ 000007) -> phase-1 j=0 hit; DONE at t0+4; DOUT=A5C, NERR=3.
- Message bit 11 flipped plus 1 parity flip -> phase-1 hit at j=1; DONE at t0+5; DOUT=A5C, NERR=2.
- Message bits 11,10,9 flipped -> phase-2 j=0 hit; DONE at t0+18; DOUT=A5C, NERR=3.
- 4 errors (message bits 11,10 plus parity bits 1,0) -> DONE at t0+31; UNCORR=1, DOUT=raw r1.
  - Repeat with EARLY_EXIT=0 and a 0-error word -> DONE at t0+31.
- RST asserted at t0+10 of a decode -> BUSY=0 next cycle, no DONE.
  - START during BUSY ignored.
  - With GOLAY_ERR_CNT_EN: 3 corrected plus 1 uncorrectable -> CORR_CNT=3, UNC_CNT=1; CNT_CLR -> 0.
